fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// fetch_ctrl_pkg : fetch controller state encoding and PC constants
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_LOAD  = 2'd0,
        FC_PRIME = 2'd1,
        FC_RUN   = 2'd2
    } fc_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : boot-loads instr_memory, then streams sequential/redirected fetches
// Optional macro FETCH_RELOAD_EN adds a reload input that returns RUN to LOAD.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          SIZE     = 256,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         LOGSIZE  = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [WIDTH-1:0]   ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
`ifdef FETCH_RELOAD_EN
    input  logic               reload,
`endif
    output logic               mem_wr_en,
    output logic [LOGSIZE+1:0] mem_wr_addr,
    output logic [WIDTH-1:0]   mem_instr_in,
    output logic [31:0]        mem_pc,
    input  logic [WIDTH-1:0]   mem_instr_out,
    output logic [31:0]        if_pc,
    output logic [WIDTH-1:0]   if_instr,
    output logic               if_valid,
    output logic               boot_done
);

    fc_state_t          r_state;
    logic [LOGSIZE-1:0] r_load_cnt;
    logic [31:0]        r_pc_q;
    logic [31:0]        r_out_pc;
    logic               r_out_valid;

    logic               w_in_load;
    logic               w_last_slot;
    logic [31:0]        w_fetch_pc;
    logic               w_unused_bits;

    assign w_in_load   = (r_state == FC_LOAD);
    assign w_last_slot = (r_load_cnt == LOGSIZE'(SIZE - 1));
    assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

    // Redirect beats stall; a stall re-reads the word currently presented.
    always_comb begin
        w_fetch_pc = RESET_PC;
        if (r_state == FC_RUN) begin
            if (redirect)
                w_fetch_pc = {redirect_pc[31:2], 2'b00};
            else if (stall)
                w_fetch_pc = r_out_pc;
            else
                w_fetch_pc = r_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FC_LOAD;
            r_load_cnt  <= '0;
            r_pc_q      <= RESET_PC;
            r_out_pc    <= RESET_PC;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                FC_LOAD: begin
                    if (ld_valid) begin
                        r_load_cnt <= r_load_cnt + LOGSIZE'(1);
                        if (ld_last || w_last_slot)
                            r_state <= FC_PRIME;
                    end
                end
                FC_PRIME: begin
                    r_out_pc    <= RESET_PC;
                    r_out_valid <= 1'b1;
                    r_pc_q      <= RESET_PC + PC_STEP;
                    r_state     <= FC_RUN;
                end
                FC_RUN: begin
                    r_out_pc <= w_fetch_pc;
                    if (redirect || !stall)
                        r_pc_q <= w_fetch_pc + PC_STEP;
`ifdef FETCH_RELOAD_EN
                    if (reload) begin
                        r_state     <= FC_LOAD;
                        r_load_cnt  <= '0;
                        r_out_valid <= 1'b0;
                    end
`endif
                end
                default: r_state <= FC_LOAD;
            endcase
        end
    end

    // Load handshake is held off while reset is asserted, not just after it.
    assign ld_ready     = w_in_load && !rst;
    assign mem_wr_en    = w_in_load && ld_valid && !rst;
    assign mem_wr_addr  = {r_load_cnt, 2'b00};
    assign mem_instr_in = ld_data;
    assign mem_pc       = w_fetch_pc;

    assign if_pc     = r_out_pc;
    assign if_instr  = mem_instr_out;
    assign if_valid  = r_out_valid && (r_state == FC_RUN);
    assign boot_done = (r_state == FC_PRIME) || (r_state == FC_RUN);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : randomized self-checking bench for fetch_ctrl (SIZE=4)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_ctrl;

    localparam int WIDTH = 32;
    localparam int SIZE  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data  = '0;
    logic        ld_last  = 1'b0;
    logic        ld_ready;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_RELOAD_EN
    logic        reload = 1'b0;
`endif
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [31:0] mem_instr_in;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr_out;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        boot_done;

    int errors = 0;
    int checks = 0;

    // Reference state: loaded image and the fetch stream's current/next address
    logic [31:0] exp_mem [SIZE];
    int          exp_cnt;
    logic [31:0] m_pc;
    logic [31:0] m_seq;

    always #5 clk = ~clk;

    fetch_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_RELOAD_EN
        .reload(reload),
`endif
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_instr_in(mem_instr_in),
        .mem_pc(mem_pc), .mem_instr_out(mem_instr_out),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .boot_done(boot_done)
    );

    // instr_memory stand-in: synchronous write, 1-cycle synchronous read, aliased
    logic [31:0] mem_arr [SIZE];
    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_wr_addr[3:2]] <= mem_instr_in;
        mem_instr_out <= mem_arr[mem_pc[3:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        logic done;
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        #1;
        chk("ld_ready", 32'(ld_ready), 32'd1);
        chk("wr_en", 32'(mem_wr_en), 32'd1);
        chk("wr_addr", 32'(mem_wr_addr), 32'(exp_cnt * 4));
        chk("wr_data", mem_instr_in, d);
        exp_mem[exp_cnt] = d;
        done = last || (exp_cnt == SIZE - 1);
        exp_cnt++;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("boot_done_load", 32'(boot_done), 32'(done));
    endtask

    task automatic load_idle();
        ld_valid = 1'b0;
        #1;
        chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
        chk("idle_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        chk("idle_boot_done", 32'(boot_done), 32'd0);
    endtask

    // PRIME cycle: an offered load word must be refused, first fetch from 0
    task automatic prime();
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        #1;
        chk("prime_ld_ready", 32'(ld_ready), 32'd0);
        chk("prime_wr_en", 32'(mem_wr_en), 32'd0);
        chk("prime_mem_pc", mem_pc, 32'h0);
        chk("prime_if_valid", 32'(if_valid), 32'd0);
        chk("prime_boot_done", 32'(boot_done), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk("first_if_pc", if_pc, 32'h0);
        chk("first_if_instr", if_instr, exp_mem[0]);
        chk("first_if_valid", 32'(if_valid), 32'd1);
        m_pc = 32'h0;
        m_seq = 32'h4;
    endtask

    task automatic run_step(input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] f;
        stall = st; redirect = rd; redirect_pc = rpc;
        if (rd)      f = rpc & 32'hFFFF_FFFC;
        else if (st) f = m_pc;
        else         f = m_seq;
        #1;
        chk("mem_pc", mem_pc, f);
        tick();
        chk("if_pc", if_pc, f);
        chk("if_instr", if_instr, exp_mem[f[3:2]]);
        chk("if_valid", 32'(if_valid), 32'd1);
        if (rd || !st) m_seq = f + 32'd4;
        m_pc = f;
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom);
    endtask

    // Asynchronous reset applied between edges; outputs must drop at once
    task automatic async_reset();
        ld_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        ld_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    initial begin
        exp_cnt = 0;
        tick();
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_valid", 32'(if_valid), 32'd0);
        chk("reset_ld_ready", 32'(ld_ready), 32'd0);
        chk("reset_boot_done", 32'(boot_done), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("release_ld_ready", 32'(ld_ready), 32'd1);

        // Basic boot: four words, last one flagged
        load_idle();
        load_word(32'h13, 1'b0);
        load_word(32'h93, 1'b0);
        load_idle();
        load_word(32'h113, 1'b0);
        load_word(32'h193, 1'b1);
        prime();

        // Sequential, stall, combined stall+redirect, aliasing, wraparound
        run_step(1'b0, 1'b0, 32'h0);
        chk("seq_pc_4", if_pc, 32'h4);
        for (int i = 0; i < 3; i++) run_step(1'b1, 1'b0, 32'h0);
        chk("stall_instr", if_instr, 32'h93);
        run_step(1'b0, 1'b0, 32'h0);
        chk("after_stall_pc", if_pc, 32'h8);
        run_step(1'b0, 1'b0, 32'h0);
        run_step(1'b1, 1'b1, 32'h0000_000E);
        chk("redirect_pc", if_pc, 32'hC);
        run_step(1'b0, 1'b0, 32'h0);
        chk("post_redirect_pc", if_pc, 32'h10);
        chk("alias_instr", if_instr, 32'h13);
        run_step(1'b0, 1'b1, 32'hFFFF_FFFD);
        run_step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc", if_pc, 32'h0);
        run_random(40);

        // Reset from RUN, then reset part-way through a load
        async_reset();
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b0);
        async_reset();

        // Fill to capacity without ld_last: depth limit ends the load
        for (int i = 0; i < SIZE; i++) load_word($urandom, 1'b0);
        prime();
        run_random(30);

        // Short image via ld_last; remaining words keep earlier contents
        async_reset();
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b1);
        prime();
        run_random(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
